// File: rtl/noaa_pkg.sv
// Shared types for the NOAA feeder / NOAA_module integration: reading width and
// the reading+mode record carried through the FIFO.
package noaa_pkg;

  localparam int TN_W = 12;

  typedef struct packed {
    logic            mode;
    logic [TN_W-1:0] tn;
  } noaa_sample_t;

endpackage

// File: rtl/noaa_sample_feeder_if.sv
// Handshake and status bundle between the mote-side producer, the feeder, and
// NOAA_module; master drives the feeder inputs, slave is the feeder itself.
interface noaa_sample_feeder_if #(
  parameter int DEPTH = 8
);
  import noaa_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;

  logic            IN_VALID;
  logic            IN_READY;
  logic [TN_W-1:0] IN_TN;
  logic            IN_MODE;
  logic            SAMPLE;
  logic [TN_W-1:0] TN;
  logic            MODE;
  logic            TN_VALID;
  logic [CW-1:0]   COUNT;
  logic            OVERFLOW;
  logic            UNDERRUN;
  logic            CLR_FLAGS;

  modport master (
    output IN_VALID, IN_TN, IN_MODE, SAMPLE, CLR_FLAGS,
    input  IN_READY, TN, MODE, TN_VALID, COUNT, OVERFLOW, UNDERRUN
  );

  modport slave (
    input  IN_VALID, IN_TN, IN_MODE, SAMPLE, CLR_FLAGS,
    output IN_READY, TN, MODE, TN_VALID, COUNT, OVERFLOW, UNDERRUN
  );

endinterface

// File: rtl/noaa_fifo_mem.sv
// Un-reset sample storage for the feeder FIFO: one synchronous write port and
// one asynchronous read port.
module noaa_fifo_mem
  import noaa_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         wr_en,
  input  logic [AW-1:0] wr_addr,
  input  noaa_sample_t wr_data,
  input  logic [AW-1:0] rd_addr,
  output noaa_sample_t rd_data
);

  noaa_sample_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/noaa_sample_feeder.sv
// First-word fall-through FIFO feeding NOAA_module one reading per SAMPLE, with
// a registered head and sticky overflow/underrun flags.
module noaa_sample_feeder
  import noaa_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  noaa_sample_feeder_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_next;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic          full;
  logic          push;
  logic          pop;
  logic          tn_valid;
  logic          overflow;
  logic          underrun;
  noaa_sample_t  in_sample;
  noaa_sample_t  mem_rd;
  noaa_sample_t  head;
  noaa_sample_t  head_next;

  assign full      = (count == CW'(DEPTH));
  assign push      = bus.IN_VALID && !full;
  assign pop       = bus.SAMPLE && tn_valid;
  assign rd_next   = pop ? rd_ptr + AW'(1) : rd_ptr;
  assign in_sample = '{mode: bus.IN_MODE, tn: bus.IN_TN};

  noaa_fifo_mem #(.DEPTH(DEPTH)) u_mem (
    .clk     (CLK),
    .wr_en   (push),
    .wr_addr (wr_ptr),
    .wr_data (in_sample),
    .rd_addr (rd_next),
    .rd_data (mem_rd)
  );

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  // The next head is being written this very edge when it sits at the write
  // pointer, so bypass the array; otherwise read it ahead at rd_next.
  always_comb begin
    head_next = head;
    if (count_next != '0) begin
      head_next = (push && (rd_next == wr_ptr)) ? in_sample : mem_rd;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      head     <= '0;
      tn_valid <= 1'b0;
      overflow <= 1'b0;
      underrun <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr   <= rd_next;
      count    <= count_next;
      head     <= head_next;
      tn_valid <= (count_next != '0);
      if (bus.IN_VALID && full)       overflow <= 1'b1;
      else if (bus.CLR_FLAGS)         overflow <= 1'b0;
      if (bus.SAMPLE && !tn_valid)    underrun <= 1'b1;
      else if (bus.CLR_FLAGS)         underrun <= 1'b0;
    end
  end

  assign bus.IN_READY = !full;
  assign bus.TN       = head.tn;
  assign bus.MODE     = head.mode;
  assign bus.TN_VALID = tn_valid;
  assign bus.COUNT    = count;
  assign bus.OVERFLOW = overflow;
  assign bus.UNDERRUN = underrun;

endmodule

// File: tb/tb_noaa_sample_feeder.sv
// Directed bench for noaa_sample_feeder: fill/overflow, streaming, underrun,
// pop-with-push at COUNT=1 and asynchronous reset mid-burst.
module tb_noaa_sample_feeder;
  import noaa_pkg::*;

  localparam int DEPTH = 8;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  noaa_sample_feeder_if #(.DEPTH(DEPTH)) bus ();

  noaa_sample_feeder #(.DEPTH(DEPTH)) dut (
    .CLK     (clk),
    .RESET_N (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [11:0] ds_tn [30] = '{1590, 2313, 2804, 1720, 1955, 2101, 2450, 1877, 1632, 2210,
                              2999, 1544, 1803, 2066, 2377, 2690, 1488, 1912, 2145, 2533,
                              1701, 2288, 2012, 1766, 2421, 1399, 2655, 1850, 2177, 2573};
  logic        ds_mode [30] = '{1, 0, 1, 1, 0, 0, 1, 0, 1, 1,
                                0, 1, 0, 0, 1, 1, 0, 1, 0, 1,
                                1, 0, 0, 1, 1, 0, 1, 0, 0, 1};
  logic [11:0] fill_tn [8] = '{1590, 2313, 2804, 401, 402, 403, 404, 405};
  logic        fill_mode [8] = '{1, 0, 1, 0, 1, 0, 1, 0};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic [11:0] tn, input logic mode,
                               input logic sample, input logic clr);
    bus.IN_VALID  = valid;
    bus.IN_TN     = tn;
    bus.IN_MODE   = mode;
    bus.SAMPLE    = sample;
    bus.CLR_FLAGS = clr;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    applyStimulus(1'b0, 12'd0, 1'b0, 1'b0, 1'b0);
    #12;
    checkOutput("rst_tn",       32'(bus.TN),       0);
    checkOutput("rst_mode",     32'(bus.MODE),     0);
    checkOutput("rst_tn_valid", 32'(bus.TN_VALID), 0);
    checkOutput("rst_count",    32'(bus.COUNT),    0);
    checkOutput("rst_in_ready", 32'(bus.IN_READY), 1);
    checkOutput("rst_overflow", 32'(bus.OVERFLOW), 0);
    checkOutput("rst_underrun", 32'(bus.UNDERRUN), 0);
    rst_n = 1'b1;
    tick();

    // Three consecutive pushes with no sampling.
    applyStimulus(1'b1, 12'd1590, 1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("push1_tn",       32'(bus.TN),       1590);
    checkOutput("push1_mode",     32'(bus.MODE),     1);
    checkOutput("push1_tn_valid", 32'(bus.TN_VALID), 1);
    applyStimulus(1'b1, 12'd2313, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 12'd2804, 1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("push3_count", 32'(bus.COUNT), 3);
    checkOutput("push3_head",  32'(bus.TN),    1590);

    // Fill to eight, then hold an extra reading against a full FIFO.
    for (int i = 3; i < 8; i++) begin
      applyStimulus(1'b1, fill_tn[i], fill_mode[i], 1'b0, 1'b0);
      tick();
    end
    checkOutput("full_count",    32'(bus.COUNT),    8);
    checkOutput("full_in_ready", 32'(bus.IN_READY), 0);
    applyStimulus(1'b1, 12'd3003, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("ovf_flag",     32'(bus.OVERFLOW), 1);
    checkOutput("ovf_count",    32'(bus.COUNT),    8);
    checkOutput("ovf_in_ready", 32'(bus.IN_READY), 0);
    applyStimulus(1'b0, 12'd0, 1'b0, 1'b0, 1'b1);
    tick();
    checkOutput("ovf_cleared", 32'(bus.OVERFLOW), 0);

    // Drain: order preserved and 3003 never appears.
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("drain_tn_%0d", i),   32'(bus.TN),   32'(fill_tn[i]));
      checkOutput($sformatf("drain_mode_%0d", i), 32'(bus.MODE), 32'(fill_mode[i]));
      applyStimulus(1'b0, 12'd0, 1'b0, 1'b1, 1'b0);
      tick();
    end
    applyStimulus(1'b0, 12'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("drain_tn_valid", 32'(bus.TN_VALID), 0);
    checkOutput("drain_count",    32'(bus.COUNT),    0);
    checkOutput("drain_hold_tn",  32'(bus.TN),       405);

    // Stream 30 readings at one per cycle with SAMPLE held from the second cycle.
    for (int i = 0; i < 30; i++) begin
      applyStimulus(1'b1, ds_tn[i], ds_mode[i], (i > 0), 1'b0);
      tick();
      checkOutput($sformatf("stream_tn_%0d", i),    32'(bus.TN),       32'(ds_tn[i]));
      checkOutput($sformatf("stream_mode_%0d", i),  32'(bus.MODE),     32'(ds_mode[i]));
      checkOutput($sformatf("stream_valid_%0d", i), 32'(bus.TN_VALID), 1);
      checkOutput($sformatf("stream_count_%0d", i), 32'(bus.COUNT),    1);
    end
    applyStimulus(1'b0, 12'd0, 1'b0, 1'b1, 1'b0);
    tick();
    checkOutput("stream_end_valid",    32'(bus.TN_VALID), 0);
    checkOutput("stream_end_underrun", 32'(bus.UNDERRUN), 0);

    // SAMPLE against an empty FIFO.
    applyStimulus(1'b0, 12'd0, 1'b0, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 12'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("udr_flag",     32'(bus.UNDERRUN), 1);
    checkOutput("udr_tn_valid", 32'(bus.TN_VALID), 0);
    checkOutput("udr_tn",       32'(bus.TN),       2573);
    checkOutput("udr_count",    32'(bus.COUNT),    0);
    applyStimulus(1'b0, 12'd0, 1'b0, 1'b0, 1'b1);
    tick();
    checkOutput("udr_cleared", 32'(bus.UNDERRUN), 0);

    // COUNT=1 with a pop and a push on the same edge.
    applyStimulus(1'b1, 12'd1468, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("one_head_tn", 32'(bus.TN), 1468);
    applyStimulus(1'b1, 12'd1138, 1'b1, 1'b1, 1'b0);
    tick();
    checkOutput("popush_tn",    32'(bus.TN),       1138);
    checkOutput("popush_mode",  32'(bus.MODE),     1);
    checkOutput("popush_valid", 32'(bus.TN_VALID), 1);
    checkOutput("popush_count", 32'(bus.COUNT),    1);

    // Build up five entries, then reset asynchronously mid-cycle.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 12'(500 + i), 1'b0, 1'b0, 1'b0);
      tick();
    end
    applyStimulus(1'b0, 12'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("pre_rst_count", 32'(bus.COUNT), 5);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_tn",       32'(bus.TN),       0);
    checkOutput("arst_tn_valid", 32'(bus.TN_VALID), 0);
    checkOutput("arst_count",    32'(bus.COUNT),    0);
    checkOutput("arst_in_ready", 32'(bus.IN_READY), 1);
    #1;
    rst_n = 1'b1;
    applyStimulus(1'b1, 12'd994, 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 12'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("post_rst_tn",    32'(bus.TN),       994);
    checkOutput("post_rst_mode",  32'(bus.MODE),     1);
    checkOutput("post_rst_valid", 32'(bus.TN_VALID), 1);
    checkOutput("post_rst_count", 32'(bus.COUNT),    1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/noaa_sample_feeder.md
# noaa_sample_feeder

Upstream feeder for `NOAA_module`: buffers temperature readings and their mode bits arriving from the mote radio interface in a small FIFO. It presents the oldest reading on `TN`/`MODE`, and it retires that reading whenever `NOAA_module` raises `SAMPLE`. This decouples bursty mote traffic from the one-reading-per-`SAMPLE` consumption of the averaging/standard-deviation stage, and reports overflow and underrun as sticky flags.

## Interface
- `DEPTH`, 8, FIFO entries; power of two, at least 2.
- `TN_W`, 12, reading width; matches `NOAA_module` `TN`.

- `CLK`  in  1  single system clock, rising edge.
- `RESET_N`  in  1  asynchronous, active-low reset.
- `IN_VALID`  in  1  upstream reading valid.
- `IN_READY`  out  1  feeder can accept this cycle.
- `IN_TN`  in  `TN_W`  reading value, unsigned.
- `IN_MODE`  in  1  1 = average request, 0 = standard-deviation request.
- `SAMPLE`  in  1  from `NOAA_module`: head reading consumed this cycle.
- `TN`  out  `TN_W`  head reading to `NOAA_module`.
- `MODE`  out  1  head mode bit to `NOAA_module`.
- `TN_VALID`  out  1  `TN`/`MODE` hold an unconsumed reading.
- `COUNT`  out  $clog2(DEPTH)+1  entries held, including the head.
- `OVERFLOW`  out  1  sticky: `IN_VALID` seen while full.
- `UNDERRUN`  out  1  sticky: `SAMPLE` seen while `TN_VALID`=0.
- `CLR_FLAGS`  in  1  synchronous clear of both sticky flags.

## Operation
- Push occurs when `IN_VALID && IN_READY`. `IN_READY = (COUNT != DEPTH)`; it is a combinational function of registered state only.
- Pop occurs when `SAMPLE && TN_VALID`. It advances the read pointer and the next entry becomes the head.
- Output is first-word fall-through. `TN`, `MODE` and `TN_VALID` are registered and always reflect the head entry.
- `COUNT` next-state rules:
  - push only: +1
  - pop only: −1
  - push and pop together: unchanged
  - neither: unchanged
- Write and read pointers are `$clog2(DEPTH)` bits and wrap modulo `DEPTH` with no special case.
- Full (`COUNT`=`DEPTH`):
  - `IN_READY`=0 even if a pop happens in the same cycle; the freed slot becomes visible the next cycle.
  - `IN_VALID`=1 in this state sets `OVERFLOW`. The input is not stored and upstream must hold it.
- Empty (`COUNT`=0):
  - `TN_VALID`=0.
  - `TN`/`MODE` hold their last values; they are 0 after reset.
  - `SAMPLE`=1 sets `UNDERRUN`; there is no pointer movement.
- Flag precedence: if `CLR_FLAGS` coincides with a new flag event, the set wins.
- Readings are passed through unmodified: no clamping, no reordering. `MODE` always travels with its own `TN`.

## Timing
- Reset values: `TN`=0, `MODE`=0, `TN_VALID`=0, `COUNT`=0, `IN_READY`=1, `OVERFLOW`=0, `UNDERRUN`=0, both pointers 0.
- Assertion of `RESET_N` mid-burst discards all entries immediately (asynchronous). The first push is allowed on the first rising edge after deassertion.
- Push into empty FIFO at edge k: `TN`/`MODE` valid and `TN_VALID`=1 after edge k, so 1-cycle latency.
- Pop at edge k with `COUNT`≥2: the next entry appears on `TN` after edge k, so back-to-back pops are possible every cycle.
- Pop at edge k with `COUNT`=1 and a simultaneous push: the pushed reading is on `TN` after edge k and `TN_VALID` stays 1.
- Pop at edge k with `COUNT`=1 and no push: `TN_VALID`=0 after edge k.
- `SAMPLE` is sampled at the rising edge only. `NOAA_module` changes `TN` inputs mid-cycle only in its own test stimulus; the feeder's outputs change only at edges.

## Structure
- Shared package `noaa_pkg`:
  - `TN_W`=12.
  - `typedef struct packed {logic mode; logic [TN_W-1:0] tn;} noaa_sample_t`.
  - This is reused by `NOAA_module` integration and the bench.
- One sub-module, `noaa_fifo_mem`:
  - `DEPTH` × `noaa_sample_t` storage.
  - One write port, one asynchronous-read port.
  - No reset on the array.
- Pointers, count, flags and the head register live in `noaa_sample_feeder`.

## Test plan
- Reset, then push (1590,1), (2313,0), (2804,1) on consecutive cycles with `SAMPLE`=0:
  - After the first push edge, `TN`=1590, `MODE`=1, `TN_VALID`=1.
  - After the third push edge, `COUNT`=3.
- Fill to 8 entries, then hold `IN_VALID`=1 with (3003,0):
  - `IN_READY`=0 and `OVERFLOW`=1.
  - `COUNT` stays 8 and 3003 is not stored.
  - `CLR_FLAGS` clears `OVERFLOW` one cycle later.
- Continuous `SAMPLE` with 30-entry dataset streamed in at one per cycle: `TN`/`MODE` sequence out exactly equals the input order (1590/1 … 2573/1) with no gaps after the first cycle, and `COUNT` stays ≤1.
- `COUNT`=1 (head 1468), simultaneous push (1138,1) and `SAMPLE`: after the edge, `TN`=1138, `TN_VALID`=1, `COUNT`=1.
- Empty FIFO, `SAMPLE`=1 for one cycle:
  - `UNDERRUN`=1 and `TN_VALID`=0.
  - `TN` keeps last value 2573 and `COUNT`=0.
- 5 entries held, `RESET_N` pulsed low mid-cycle: outputs go to reset values before the next edge, `IN_READY`=1, and a subsequent push of (994,1) appears on `TN` one edge later.
